// File: rtl/silife_wb_loader.sv
`default_nettype none
// ============================================================================
// Module   : silife_wb_loader
// Brief    : Wishbone classic initiator that loads a WIDTHxHEIGHT pattern plus
//            the control word into SiLife, or dumps all rows into a snapshot.
// Revision : 1.0 - initial release
// ============================================================================
module silife_wb_loader #(
   parameter int          WIDTH     = 8,
   parameter int          HEIGHT    = 8,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int          TIMEOUT   = 16
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    start_load,
   input  logic                    start_dump,
   input  logic [WIDTH*HEIGHT-1:0] load_cells,
   input  logic [2:0]              ctrl_value,
   output logic [WIDTH*HEIGHT-1:0] dump_cells,
   output logic                    busy,
   output logic                    done,
   output logic                    error,
   output logic                    o_wb_cyc,
   output logic                    o_wb_stb,
   output logic                    o_wb_we,
   output logic [3:0]              o_wb_sel,
   output logic [31:0]             o_wb_addr,
   output logic [31:0]             o_wb_data,
   input  logic                    i_wb_ack,
   input  logic [31:0]             i_wb_data
);

   localparam int          ROW_W      = $clog2(HEIGHT + 1);
   localparam int          WAIT_W     = $clog2(TIMEOUT + 1);
   localparam logic [31:0] c_row_base = BASE_ADDR + 32'h1000;

   localparam logic [1:0] c_idle   = 2'd0;
   localparam logic [1:0] c_req    = 2'd1;
   localparam logic [1:0] c_gap    = 2'd2;
   localparam logic [1:0] c_finish = 2'd3;

   logic [1:0]              r_state;
   logic [1:0]              w_next;
   logic                    r_is_load;
   logic [WIDTH*HEIGHT-1:0] r_cells;
   logic [2:0]              r_ctrl;
   logic [ROW_W-1:0]        r_row;
   logic [WAIT_W-1:0]       r_wait;
   logic                    w_accept;
   logic                    w_ack;
   logic                    w_last;
   logic                    w_timeout;
   logic                    w_ctrl_phase;
   logic [WIDTH-1:0]        w_row_bits;
   logic                    w_unused;

   assign w_accept     = (r_state == c_idle) && (start_load || start_dump);
   assign w_ack        = (r_state == c_req) && i_wb_ack;
   assign w_ctrl_phase = r_is_load && (r_row == ROW_W'(HEIGHT));
   assign w_last       = r_is_load ? w_ctrl_phase : (r_row == ROW_W'(HEIGHT - 1));
   assign w_timeout    = (r_state == c_req) && !i_wb_ack && (r_wait == WAIT_W'(TIMEOUT - 1));
   assign w_unused     = &{1'b0, i_wb_data};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= c_idle;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         c_idle:   if (w_accept) w_next = c_req;
         c_req: begin
            if (w_ack)          w_next = w_last ? c_finish : c_gap;
            else if (w_timeout) w_next = c_finish;
         end
         c_gap:    w_next = c_req;
         c_finish: w_next = c_idle;
         default:  w_next = c_idle;
      endcase
   end

   // Command latch, counters, sticky error and the read snapshot.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_is_load  <= 1'b0;
         r_cells    <= '0;
         r_ctrl     <= '0;
         r_row      <= '0;
         r_wait     <= '0;
         error      <= 1'b0;
         dump_cells <= '0;
      end else begin
         if (w_accept) begin
            r_is_load <= start_load;
            r_row     <= '0;
            error     <= 1'b0;
            if (start_load) begin
               r_cells <= load_cells;
               r_ctrl  <= ctrl_value;
            end
         end
         if (r_state != c_req || i_wb_ack) r_wait <= '0;
         else                              r_wait <= r_wait + 1'b1;
         if (w_ack && !w_last) r_row <= r_row + 1'b1;
         if (w_timeout) error <= 1'b1;
         if (w_ack && !r_is_load) begin
            for (int i = 0; i < HEIGHT; i++) begin
               if (r_row == ROW_W'(i)) dump_cells[i*WIDTH +: WIDTH] <= i_wb_data[WIDTH-1:0];
            end
         end
      end
   end

   always_comb begin
      w_row_bits = '0;
      for (int i = 0; i < HEIGHT; i++) begin
         if (r_row == ROW_W'(i)) w_row_bits = r_cells[i*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      o_wb_cyc  = 1'b0;
      o_wb_stb  = 1'b0;
      o_wb_we   = 1'b0;
      o_wb_sel  = 4'hF;
      o_wb_addr = '0;
      o_wb_data = '0;
      busy      = (r_state != c_idle);
      done      = (r_state == c_finish);
      if (r_state == c_req) begin
         o_wb_cyc = 1'b1;
         o_wb_stb = 1'b1;
         o_wb_we  = r_is_load;
         if (w_ctrl_phase) begin
            o_wb_addr = BASE_ADDR;
            o_wb_data = {29'b0, r_ctrl};
         end else begin
            o_wb_addr = c_row_base + 32'({r_row, 2'b00});
            if (r_is_load) o_wb_data[WIDTH-1:0] = w_row_bits;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_silife_wb_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_silife_wb_loader
// Brief    : Directed/randomized bench with a SiLife responder model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_silife_wb_loader;

   localparam int          W    = 8;
   localparam int          H    = 8;
   localparam int          TO   = 16;
   localparam logic [31:0] BASE = 32'h3000_0000;
   localparam logic [63:0] MASK = 64'hFF;

   logic        clk;
   logic        reset_n;
   logic        start_load, start_dump;
   logic [63:0] load_cells, dump_cells;
   logic [2:0]  ctrl_value;
   logic        busy, done, error;
   logic        o_wb_cyc, o_wb_stb, o_wb_we;
   logic [3:0]  o_wb_sel;
   logic [31:0] o_wb_addr, o_wb_data, i_wb_data;
   logic        i_wb_ack;

   silife_wb_loader #(.WIDTH(W), .HEIGHT(H), .BASE_ADDR(BASE), .TIMEOUT(TO)) dut (
      .clk(clk), .reset_n(reset_n), .start_load(start_load), .start_dump(start_dump),
      .load_cells(load_cells), .ctrl_value(ctrl_value), .dump_cells(dump_cells),
      .busy(busy), .done(done), .error(error),
      .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_sel(o_wb_sel),
      .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .i_wb_ack(i_wb_ack), .i_wb_data(i_wb_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Responder model: registered ack, optional extra wait on one row.
   logic        resp_ack, spur, unstable, prev_stb;
   logic [64:0] prev_vec;
   int          resp_cnt, slow_row, slow_cyc, rd_idx;
   bit          no_ack;
   logic [31:0] mem_row [H];
   logic [31:0] mem_ctrl, rd_junk;
   logic [31:0] log_addr[$], log_data[$];
   logic        log_we[$];
   int          n_pass, n_fail, n_checks;

   function automatic int row_of(input logic [31:0] a);
      if (a >= BASE + 32'h1000 && a < BASE + 32'h1000 + 32'(4*H)) return int'((a - BASE - 32'h1000) >> 2);
      return -1;
   endfunction

   assign i_wb_ack  = resp_ack | spur;
   assign rd_idx    = row_of(o_wb_addr);
   assign i_wb_data = (rd_idx >= 0) ? ((rd_junk & ~32'hFF) | (mem_row[rd_idx] & 32'hFF)) : rd_junk;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         resp_ack <= 1'b0;
         resp_cnt <= 0;
      end else if (o_wb_stb && !resp_ack && !no_ack) begin
         if (resp_cnt >= ((row_of(o_wb_addr) == slow_row) ? slow_cyc : 0)) begin
            resp_ack <= 1'b1;
            resp_cnt <= 0;
         end else resp_cnt <= resp_cnt + 1;
      end else begin
         resp_ack <= 1'b0;
         if (!o_wb_stb) resp_cnt <= 0;
      end
   end

   always @(negedge clk) begin
      if (o_wb_stb && i_wb_ack) begin
         log_addr.push_back(o_wb_addr);
         log_data.push_back(o_wb_data);
         log_we.push_back(o_wb_we);
         if (o_wb_we) begin
            if (o_wb_addr == BASE) mem_ctrl = o_wb_data;
            else if (row_of(o_wb_addr) >= 0) mem_row[row_of(o_wb_addr)] = o_wb_data;
         end
      end
      if (prev_stb && o_wb_stb && {o_wb_addr, o_wb_data, o_wb_we} !== prev_vec) unstable = 1'b1;
      prev_stb = o_wb_stb;
      prev_vec = {o_wb_addr, o_wb_data, o_wb_we};
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_log();
      log_addr.delete();
      log_data.delete();
      log_we.delete();
   endtask

   // Expected transfer list derived from the address map and command type.
   task automatic check_xfers(input string tag, input bit ld, input logic [63:0] cells, input logic [2:0] ctrl);
      int n;
      logic [31:0] ea, ed;
      n = ld ? H + 1 : H;
      check({tag, "_count"}, 64'(log_addr.size()), 64'(n));
      for (int i = 0; i < n && i < log_addr.size(); i++) begin
         ea = (ld && i == H) ? BASE : BASE + 32'h1000 + 32'(4*i);
         ed = (ld && i == H) ? {29'b0, ctrl} : 32'((cells >> (i*W)) & MASK);
         check($sformatf("%s_addr%0d", tag, i), 64'(log_addr[i]), 64'(ea));
         check($sformatf("%s_we%0d", tag, i), 64'(log_we[i]), 64'(ld));
         if (ld) check($sformatf("%s_data%0d", tag, i), 64'(log_data[i]), 64'(ed));
      end
   endtask

   task automatic run_cmd(input bit ld, input bit dp, input logic [63:0] cells, input logic [2:0] ctrl,
                          input bit busy_dump, input bit spur_gap,
                          output int done_cyc, output int stb_cyc, output int done_cnt,
                          output logic err0, output logic busy_end);
      int  k;
      bit  spur_used;
      clear_log();
      done_cyc = -1; stb_cyc = 0; done_cnt = 0; k = 0; spur_used = 0;
      start_load = ld; start_dump = dp; load_cells = cells; ctrl_value = ctrl;
      @(posedge clk);
      #1;
      start_load = 1'b0; start_dump = 1'b0;
      load_cells = {$urandom, $urandom}; ctrl_value = 3'($urandom);
      err0 = error;
      while (k < 2000) begin
         if (o_wb_stb) stb_cyc++;
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = k;
         end
         if (done_cyc >= 0 && k == done_cyc + 3) break;
         start_dump = busy_dump && (k == 4);
         if (spur_gap && !spur_used && busy && !o_wb_stb && !done && k > 0) begin
            spur = 1'b1;
            spur_used = 1;
         end else spur = 1'b0;
         @(posedge clk);
         #1;
         k++;
      end
      spur = 1'b0; start_dump = 1'b0;
      busy_end = busy;
      if (done_cyc < 0) check("cmd_done_seen", 64'(done_cyc), 64'd0);
   endtask

   logic [63:0] pat, exp_dump;
   logic [2:0]  ctl;
   logic        e0, bend;
   int          dc, sc, dn, guard;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1);
   end

   initial begin
      n_pass = 0; n_fail = 0; n_checks = 0;
      reset_n = 1'b0; start_load = 1'b0; start_dump = 1'b0; load_cells = '0; ctrl_value = '0;
      spur = 1'b0; no_ack = 0; slow_row = -5; slow_cyc = 0; unstable = 1'b0; prev_stb = 1'b0;
      rd_junk = $urandom; mem_ctrl = '0;
      for (int i = 0; i < H; i++) mem_row[i] = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_ctl", 64'({o_wb_cyc, o_wb_stb, o_wb_we, busy, done, error}), 64'd0);
      check("reset_addr_data", {o_wb_addr, o_wb_data}, 64'd0);
      check("reset_dump", dump_cells, 64'd0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Blinker load and dump.
      pat = 64'h0000_0000_0038_0000;
      run_cmd(1, 0, pat, 3'b001, 0, 0, dc, sc, dn, e0, bend);
      check_xfers("blink_ld", 1, pat, 3'b001);
      if (log_data.size() == H + 1) begin
         check("blink_row2", 64'(log_data[2]), 64'h38);
         check("blink_ctrl", 64'(log_data[H]), 64'h1);
      end
      check("blink_done_cycle", 64'(dc + 1), 64'(3*(H+1)));
      check("blink_done_pulse", 64'(dn), 64'd1);
      check("blink_error", 64'(error), 64'd0);
      check("blink_busy_end", 64'(bend), 64'd0);
      run_cmd(0, 1, '0, 3'b000, 0, 0, dc, sc, dn, e0, bend);
      check_xfers("blink_dp", 0, '0, 3'b000);
      check("blink_dump", dump_cells, pat);
      check("blink_dump_cycle", 64'(dc + 1), 64'(3*H));
      exp_dump = pat;

      // Randomized load/dump round trips.
      for (int t = 0; t < 3; t++) begin
         pat = {$urandom, $urandom}; ctl = 3'($urandom); rd_junk = $urandom;
         run_cmd(1, 0, pat, ctl, 0, 0, dc, sc, dn, e0, bend);
         check_xfers($sformatf("rnd%0d_ld", t), 1, pat, ctl);
         check($sformatf("rnd%0d_ctrl_mem", t), 64'(mem_ctrl), 64'({29'b0, ctl}));
         run_cmd(0, 1, '0, 3'b000, 0, 0, dc, sc, dn, e0, bend);
         check($sformatf("rnd%0d_dump", t), dump_cells, pat);
         exp_dump = pat;
      end

      // Timeout on a dump with a dead responder.
      no_ack = 1;
      run_cmd(0, 1, '0, 3'b000, 0, 0, dc, sc, dn, e0, bend);
      check("to_stb_cycles", 64'(sc), 64'(TO));
      check("to_error", 64'(error), 64'd1);
      check("to_done_pulse", 64'(dn), 64'd1);
      check("to_done_cycle", 64'(dc + 1), 64'(TO + 1));
      check("to_no_xfers", 64'(log_addr.size()), 64'd0);
      check("to_dump_kept", dump_cells, exp_dump);
      no_ack = 0;
      pat = {$urandom, $urandom}; ctl = 3'($urandom);
      run_cmd(1, 0, pat, ctl, 0, 0, dc, sc, dn, e0, bend);
      check("to_err_cleared", 64'(e0), 64'd0);
      check("to_err_after", 64'(error), 64'd0);
      check_xfers("to_recover_ld", 1, pat, ctl);

      // Simultaneous starts, then a dump pulse while busy.
      pat = {$urandom, $urandom}; ctl = 3'($urandom);
      run_cmd(1, 1, pat, ctl, 1, 0, dc, sc, dn, e0, bend);
      check_xfers("both_ld", 1, pat, ctl);
      clear_log();
      repeat (10) @(posedge clk);
      #1;
      check("both_no_dump", 64'(log_addr.size()), 64'd0);
      check("both_idle", 64'(busy), 64'd0);

      // Wait states on row 3 and a spurious ack in a gap.
      slow_row = 3; slow_cyc = 5; unstable = 1'b0;
      pat = {$urandom, $urandom}; ctl = 3'($urandom);
      run_cmd(1, 0, pat, ctl, 0, 0, dc, sc, dn, e0, bend);
      check_xfers("ws_ld", 1, pat, ctl);
      check("ws_ld_cycle", 64'(dc + 1), 64'(3*(H+1) + 5));
      run_cmd(0, 1, '0, 3'b000, 0, 1, dc, sc, dn, e0, bend);
      check_xfers("ws_dp", 0, '0, 3'b000);
      check("ws_dump", dump_cells, pat);
      check("ws_dp_cycle", 64'(dc + 1), 64'(3*H + 5));
      check("ws_stable", 64'(unstable), 64'd0);
      slow_row = -5; slow_cyc = 0;

      // Reset in the middle of a load at row 4.
      clear_log();
      pat = {$urandom, $urandom};
      start_load = 1'b1; load_cells = pat; ctrl_value = 3'b101;
      @(posedge clk);
      #1;
      start_load = 1'b0;
      guard = 0;
      while (!(log_addr.size() == 4 && o_wb_stb) && guard < 200) begin
         @(posedge clk);
         #1;
         guard++;
      end
      check("rst_reach_row4", 64'(guard < 200), 64'd1);
      reset_n = 1'b0;
      #1;
      check("rst_async_drop", 64'({o_wb_cyc, o_wb_stb, busy, done}), 64'd0);
      dn = 0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (done) dn++;
      end
      check("rst_no_done", 64'(dn), 64'd0);
      reset_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_idle_ctl", 64'({o_wb_cyc, o_wb_stb, o_wb_we, busy, done, error}), 64'd0);
      check("rst_idle_addr_data", {o_wb_addr, o_wb_data}, 64'd0);
      check("rst_idle_dump", dump_cells, 64'd0);
      check("rst_no_more_xfers", 64'(log_addr.size()), 64'd4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
